// File: rtl/fetch_unit.sv
// Instruction fetch: synchronous-read instruction memory feeding a small
// PC-tagged fetch queue, with redirect flush and valid/ready output.
module fetch_unit #(
   parameter int ADDR_W     = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int QDEPTH     = 4,
   parameter int RESET_PC   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_pc,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [31:0]                   out_instr,
   output logic [ADDR_W-1:0]             out_pc,
   output logic [ADDR_W-1:0]             out_pc_nxt,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
   output logic [$clog2(QDEPTH):0]       q_count
);

   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int QW = $clog2(QDEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]       r_mem [IMEM_DEPTH];
   logic [31:0]       r_rdata;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_infl_pc;
   logic              r_infl;

   logic [31:0]       r_q_instr [QDEPTH];
   logic [ADDR_W-1:0] r_q_pc [QDEPTH];
   logic [QW-1:0]     r_wptr;
   logic [QW-1:0]     r_rptr;
   logic [QW:0]       r_count;

   logic [QW+1:0]     w_occ;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;

   // Queue slots already promised: stored entries plus the read in flight.
   assign w_occ   = {1'b0, r_count} + (QW+2)'(r_infl);
   assign w_issue = !redirect_valid && (w_occ < (QW+2)'(QDEPTH));
   assign w_push  = !redirect_valid && r_infl &&
                    (r_count != (QW+1)'(QDEPTH));
   assign w_pop   = !redirect_valid && out_valid && out_ready;

   // Memory write port and registered read; same-index read sees old data.
   always_ff @(posedge clk) begin
      if (imem_we)
         r_mem[imem_waddr] <= imem_wdata;
      if (w_issue)
         r_rdata <= r_mem[r_fetch_pc[IW-1:0]];
   end

   // Fetch PC and in-flight read tracking; redirect drops the in-flight read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= ADDR_W'(RESET_PC);
         r_infl     <= 1'b0;
         r_infl_pc  <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc;
         r_infl     <= 1'b0;
      end else begin
         r_infl <= w_issue;
         if (w_issue) begin
            r_infl_pc  <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
         end
      end
   end

   // Queue payload storage, written at the tail on push.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_instr[r_wptr] <= r_rdata;
         r_q_pc[r_wptr]    <= r_infl_pc;
      end
   end

   // Queue pointers and occupancy; redirect empties the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + QW'(1);
         if (w_pop)
            r_rptr <= r_rptr + QW'(1);
         r_count <= r_count + (QW+1)'(w_push) - (QW+1)'(w_pop);
      end
   end

   assign out_valid  = (r_count != '0);
   assign q_count    = r_count;
   assign out_instr  = out_valid ? r_q_instr[r_rptr] : NOP;
   assign out_pc     = out_valid ? r_q_pc[r_rptr] : '0;
   assign out_pc_nxt = out_valid ? r_q_pc[r_rptr] + ADDR_W'(1) : '0;

endmodule
